// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared codes and state encoding for the BLDC command bridge
package bldc_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  localparam logic REG_CTRL = 1'b0;
  localparam logic REG_STAT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_RD_WAIT,
    ST_SEND
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage

// File: rtl/bldc_frame_timer.sv
// rtl/bldc_frame_timer.sv - reloadable inter-byte timeout counter
module bldc_frame_timer #(
  parameter int TIMEOUT = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  assign expired = run && (32'(cnt) == TIMEOUT);

  // Count idle cycles while a frame is open; restart on every byte or expiry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || expired) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bldc_cmd_bridge.sv
// rtl/bldc_cmd_bridge.sv - UART byte stream to bldc_registers bus initiator
module bldc_cmd_bridge
  import bldc_pkg::*;
#(
  parameter int TIMEOUT = 5000,
  parameter int RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        write,
  output logic        read,
  output logic        addr,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  output logic        busy,
  output logic        overrun
);

  localparam int RW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t        state, state_n;
  logic          cmd_wr;
  logic          addr_pend;
  logic [1:0]    byte_cnt;
  logic [23:0]   wr_shift;
  logic [31:0]   tx_shift;
  logic [1:0]    tx_left;
  logic [RW-1:0] rd_cnt;
  logic          timer_run, expired;
  logic          idle_like, bad_addr, rd_done, drop;

  assign timer_run = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
  // An expired frame behaves like IDLE so a byte on the expiry edge opens a new frame.
  assign idle_like = (state == ST_IDLE) || expired;
  assign bad_addr  = rx_data > {7'd0, REG_STAT};
  assign rd_done   = (32'(rd_cnt) == RD_LAT - 1);
  assign drop      = rx_valid && ((state == ST_BUS_WR) || (state == ST_BUS_RD) ||
                                  (state == ST_RD_WAIT) || (state == ST_SEND));

  bldc_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid || !timer_run),
    .run     (timer_run),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_n  = state;
    write    = 1'b0;
    read     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != ST_IDLE);
    if (idle_like) begin
      state_n = ST_IDLE;
      if (rx_valid) state_n = is_cmd(rx_data) ? ST_GET_ADDR : ST_SEND;
    end else begin
      case (state)
        ST_GET_ADDR: if (rx_valid) state_n = bad_addr ? ST_SEND : (cmd_wr ? ST_GET_DATA : ST_BUS_RD);
        ST_GET_DATA: if (rx_valid && byte_cnt == 2'd3) state_n = ST_BUS_WR;
        ST_BUS_WR: begin
          write   = 1'b1;
          state_n = ST_SEND;
        end
        ST_BUS_RD: begin
          read    = 1'b1;
          state_n = ST_RD_WAIT;
        end
        ST_RD_WAIT: if (rd_done) state_n = ST_SEND;
        ST_SEND: begin
          tx_valid = 1'b1;
          tx_data  = tx_shift[31:24];
          if (tx_ready && tx_left == 2'd0) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Frame datapath: address/data capture, bus registers and response shifter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_wr    <= 1'b0;
      addr_pend <= REG_CTRL;
      addr      <= REG_CTRL;
      byte_cnt  <= 2'd0;
      wr_shift  <= 24'h0;
      data_in   <= 32'h0;
      tx_shift  <= 32'h0;
      tx_left   <= 2'd0;
      rd_cnt    <= '0;
      overrun   <= 1'b0;
    end else begin
      if (drop) overrun <= 1'b1;
      if (idle_like) begin
        if (rx_valid) begin
          cmd_wr <= (rx_data == CMD_WR);
          if (!is_cmd(rx_data)) begin
            tx_shift <= {RSP_ERR, 24'h0};
            tx_left  <= 2'd0;
          end
        end
      end else begin
        case (state)
          ST_GET_ADDR: if (rx_valid) begin
            addr_pend <= rx_data[0];
            byte_cnt  <= 2'd0;
            if (bad_addr) begin
              tx_shift <= {RSP_ERR, 24'h0};
              tx_left  <= 2'd0;
            end else if (!cmd_wr) begin
              addr <= rx_data[0];
            end
          end
          ST_GET_DATA: if (rx_valid) begin
            wr_shift <= {wr_shift[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              data_in <= {wr_shift, rx_data};
              addr    <= addr_pend;
            end
          end
          ST_BUS_WR: begin
            tx_shift <= {RSP_ACK, 24'h0};
            tx_left  <= 2'd0;
          end
          ST_BUS_RD: rd_cnt <= '0;
          ST_RD_WAIT: begin
            rd_cnt <= rd_cnt + RW'(1);
            if (rd_done) begin
              tx_shift <= data_out;
              tx_left  <= 2'd3;
            end
          end
          ST_SEND: if (tx_ready) begin
            tx_shift <= {tx_shift[23:0], 8'h00};
            tx_left  <= tx_left - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bldc_cmd_bridge.sv
// tb/tb_bldc_cmd_bridge.sv - self-checking bench for bldc_cmd_bridge
module tb_bldc_cmd_bridge;

  localparam int TO = 20;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        write, read, addr;
  logic [31:0] data_in;
  logic [31:0] data_out = 32'h0;
  logic        busy, overrun;

  bldc_cmd_bridge #(.TIMEOUT(TO), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .write(write), .read(read), .addr(addr), .data_in(data_in),
    .data_out(data_out), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int n_rd  = 0;
  logic [7:0]  exp_tx_q[$];
  logic [32:0] exp_wr_q[$];
  logic        stall_pend = 1'b0;
  logic [7:0]  stall_data = 8'h00;

  typedef struct {
    logic [47:0] b;
    int          nb;
    logic [31:0] rdat;
    int          nwr;
    logic        wa;
    logic [31:0] wd;
    int          nrd;
    logic [31:0] t;
    int          nt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) step();
    chk("idle_bound", busy, 1'b0);
  endtask

  // Scoreboard monitor: pops expected bytes/writes as the DUT produces them.
  always @(negedge clk) begin
    logic [32:0] e;
    logic [7:0]  eb;
    if (rst) begin
      if (write || read) chk("wr_rd_excl", write && read, 1'b0);
      if (read) n_rd++;
      if (write) begin
        n_wr++;
        chk("wr_expected", exp_wr_q.size() != 0, 1'b1);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", addr, e[32]);
          chk("wr_data", data_in, e[31:0]);
        end
      end
      if (stall_pend) begin
        chk("stall_valid", tx_valid, 1'b1);
        chk("stall_data", tx_data, stall_data);
      end
      if (tx_valid && tx_ready) begin
        chk("tx_expected", exp_tx_q.size() != 0, 1'b1);
        if (exp_tx_q.size() != 0) begin
          eb = exp_tx_q.pop_front();
          chk("tx_byte", tx_data, eb);
        end
      end
      stall_pend = tx_valid && !tx_ready;
      stall_data = tx_data;
    end else begin
      stall_pend = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wr0, rd0;

    vecs[0] = '{48'h570003808000, 6, 32'h0,        1, 1'b0, 32'h03808000, 0, 32'h4B000000, 1};
    vecs[1] = '{48'h5701DEADBEEF, 6, 32'h0,        1, 1'b1, 32'hDEADBEEF, 0, 32'h4B000000, 1};
    vecs[2] = '{48'h520100000000, 2, 32'h03808000, 0, 1'b0, 32'h0,        1, 32'h03808000, 4};
    vecs[3] = '{48'h520000000000, 2, 32'hA55A0FF0, 0, 1'b0, 32'h0,        1, 32'hA55A0FF0, 4};
    vecs[4] = '{48'h410000000000, 1, 32'h0,        0, 1'b0, 32'h0,        0, 32'h45000000, 1};
    vecs[5] = '{48'h570200000000, 2, 32'h0,        0, 1'b0, 32'h0,        0, 32'h45000000, 1};
    vecs[6] = '{48'h52FF00000000, 2, 32'h0,        0, 1'b0, 32'h0,        0, 32'h45000000, 1};
    vecs[7] = '{48'h000000000000, 1, 32'h0,        0, 1'b0, 32'h0,        0, 32'h45000000, 1};

    // Reset values.
    repeat (3) step();
    chk("rst_write", write, 1'b0);
    chk("rst_read", read, 1'b0);
    chk("rst_addr", addr, 1'b0);
    chk("rst_data_in", data_in, 32'h0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b1;
    step();

    // Table-driven frames.
    for (int v = 0; v < 8; v++) begin
      wr0 = n_wr;
      rd0 = n_rd;
      data_out = vecs[v].rdat;
      if (vecs[v].nwr != 0) exp_wr_q.push_back({vecs[v].wa, vecs[v].wd});
      for (int k = 0; k < vecs[v].nt; k++) exp_tx_q.push_back(vecs[v].t[31-8*k -: 8]);
      for (int k = 0; k < vecs[v].nb; k++) send_byte(vecs[v].b[47-8*k -: 8]);
      wait_idle();
      chk("vec_writes", n_wr - wr0, vecs[v].nwr);
      chk("vec_reads", n_rd - rd0, vecs[v].nrd);
      chk("vec_tx_left", exp_tx_q.size(), 0);
    end

    // Write strobe timing and held bus outputs.
    exp_wr_q.push_back({1'b1, 32'h12345678});
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    chk("wt_no_early_write", write, 1'b0);
    send_byte(8'h78);
    chk("wt_write", write, 1'b1);
    chk("wt_read", read, 1'b0);
    chk("wt_addr", addr, 1'b1);
    chk("wt_data", data_in, 32'h12345678);
    step();
    chk("wt_write_off", write, 1'b0);
    chk("wt_ack_valid", tx_valid, 1'b1);
    chk("wt_ack_data", tx_data, 8'h4B);
    chk("wt_data_hold", data_in, 32'h12345678);
    wait_idle();

    // Read latency, capture point, and stalled transmitter.
    tx_ready = 1'b0;
    data_out = 32'hC0FFEE11;
    exp_tx_q.push_back(8'hC0); exp_tx_q.push_back(8'hFF);
    exp_tx_q.push_back(8'hEE); exp_tx_q.push_back(8'h11);
    send_byte(8'h52);
    send_byte(8'h01);
    chk("rd_strobe", read, 1'b1);
    chk("rd_addr", addr, 1'b1);
    for (int i = 0; i < RL; i++) begin
      step();
      chk("rd_wait_read", read, 1'b0);
      chk("rd_wait_txv", tx_valid, 1'b0);
    end
    step();
    chk("rd_txv_rise", tx_valid, 1'b1);
    chk("rd_first", tx_data, 8'hC0);
    data_out = 32'h0;
    for (int k = 0; k < 4; k++) begin
      repeat (10) step();
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_idle();
    chk("rd_tx_left", exp_tx_q.size(), 0);

    // Timeout with a long gap: no write, no response.
    wr0 = n_wr;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h03);
    repeat (TO + 2) step();
    chk("to_busy", busy, 1'b0);
    chk("to_no_write", n_wr - wr0, 0);
    chk("to_no_tx", tx_valid, 1'b0);

    // Byte on the expiry edge opens a new frame.
    exp_tx_q.push_back(8'h45);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h03);
    repeat (TO) step();
    chk("to_edge_busy", busy, 1'b1);
    send_byte(8'h41);
    chk("to_edge_err_valid", tx_valid, 1'b1);
    chk("to_edge_err_data", tx_data, 8'h45);
    wait_idle();
    chk("to_edge_no_write", n_wr - wr0, 0);

    // Normal write after a timeout.
    exp_wr_q.push_back({1'b1, 32'hAABBCCDD});
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_idle();
    chk("to_recover_write", n_wr - wr0, 1);

    // Overrun while SEND is stalled.
    tx_ready = 1'b0;
    exp_tx_q.push_back(8'h45);
    send_byte(8'h41);
    chk("ov_err_valid", tx_valid, 1'b1);
    chk("ov_err_data", tx_data, 8'h45);
    chk("ov_before", overrun, 1'b0);
    send_byte(8'h57);
    chk("ov_set", overrun, 1'b1);
    chk("ov_data_hold", tx_data, 8'h45);
    tx_ready = 1'b1;
    wait_idle();
    repeat (3) step();
    chk("ov_no_frame", busy, 1'b0);
    chk("ov_sticky", overrun, 1'b1);
    chk("ov_tx_left", exp_tx_q.size(), 0);

    // Reset in the middle of GET_DATA.
    wr0 = n_wr;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b0;
    step();
    chk("mr_write", write, 1'b0);
    chk("mr_read", read, 1'b0);
    chk("mr_addr", addr, 1'b0);
    chk("mr_data_in", data_in, 32'h0);
    chk("mr_tx_valid", tx_valid, 1'b0);
    chk("mr_tx_data", tx_data, 8'h00);
    chk("mr_busy", busy, 1'b0);
    chk("mr_overrun", overrun, 1'b0);
    step();
    rst = 1'b1;
    repeat (10) step();
    chk("mr_no_write", n_wr - wr0, 0);
    chk("mr_idle", busy, 1'b0);
    chk("end_wr_q", exp_wr_q.size(), 0);
    chk("end_tx_q", exp_tx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
